// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch front-end.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_4;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO of fetched instructions; head is read straight from storage.
module prefetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               clear,
    output logic [CW-1:0]      count,
    output fetch_entry_t       head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch front-end: issues credit-limited word reads, buffers responses, re-steers on redirect.
module instr_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc_4,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc_4;
    logic            run;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   drop;
    logic [CW:0]     credit_used;
    logic            issue;
    logic            push;
    logic            pop;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    // Credits cover both buffered entries and outstanding reads, so the FIFO can never overflow.
    assign credit_used    = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = run & ~redirect & (credit_used < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign issue          = imem_req_valid & imem_req_ready;
    assign inflight_next  = inflight + CW'(issue) - CW'(imem_rsp_valid);

    assign push      = imem_rsp_valid & ~redirect & (drop == '0);
    assign pop       = out_valid & out_ready & ~redirect;
    assign push_data = '{instr: imem_rsp_data, pc_4: rsp_pc_4};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run      <= 1'b0;
            fetch_pc <= RESET_PC;
            rsp_pc_4 <= RESET_PC + STEP;
            inflight <= '0;
            drop     <= '0;
        end else begin
            run      <= 1'b1;
            inflight <= inflight_next;
            if (redirect) begin
                fetch_pc <= align_pc(redirect_pc);
                rsp_pc_4 <= align_pc(redirect_pc) + STEP;
                drop     <= inflight_next;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + STEP;
                end
                if (imem_rsp_valid && drop != '0) begin
                    drop <= drop - CW'(1);
                end
                // Responses are in order, so the next kept word's PC+4 simply advances.
                if (push) begin
                    rsp_pc_4 <= rsp_pc_4 + STEP;
                end
            end
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (redirect),
        .count     (count),
        .head      (head)
    );

    assign out_valid = (count != '0);
    assign out_instr = head.instr;
    assign out_pc_4  = head.pc_4;

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
- Fetch front-end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word reads to instruction memory through a valid/ready request channel with in-order responses.
- Buffers returned instructions, each paired with its PC+4, in a small FIFO.
- Presents the FIFO head to IF/ID; stalls when the hazard unit holds IF/ID, and flushes plus re-steers on a taken branch.

Parameters:
- DEPTH, 4, FIFO entries and maximum in-flight requests combined (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address (word aligned)
- imem_rsp_valid  in  1  response valid; in order, at most one per cycle, never back-pressured
- imem_rsp_data  in  32  instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  IF/ID consumes head (driven by IF_ID_Write AND PCWrite)
- out_instr  out  32  head instruction
- out_pc_4  out  32  head PC+4
- redirect  in  1  taken branch / flush
- redirect_pc  in  32  new fetch address

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; count=0; inflight=0; drop=0; run=0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_instr=0, out_pc_4=0.
- run flop: set on the first clk edge after reset release. Gates imem_req_valid, so no request is issued during the reset cycle.
- Credit rule: imem_req_valid = run & ~redirect & (count + inflight < DEPTH). Uses current-cycle count, so a same-cycle pop does not free a credit.
- Request issue:
  - Issue occurs when imem_req_valid & imem_req_ready.
  - On issue: inflight+1; fetch_pc += 4; FIFO tag for the request = fetch_pc+4.
  - imem_req_addr = fetch_pc, held stable while valid and not ready.
- Response handling:
  - On imem_rsp_valid: inflight-1.
  - If drop>0: discard the response and drop-1.
  - Otherwise push {instr, pc_4} into the FIFO. pc_4 comes from a tag queue, or from a pc_4 counter advanced per accepted response (implementer's choice; same result).
- Output:
  - out_valid = count>0. out_instr and out_pc_4 are registered FIFO head, with no bypass.
  - Pop occurs when out_valid & out_ready & ~redirect.
  - Minimum latency from issue to out_valid = memory latency + 1 cycle.
- Same-cycle push and pop: count unchanged; ordering preserved.
- Overflow cannot occur by construction. An assertion in the bench checks count ≤ DEPTH.
- Redirect (takes effect at the clk edge where redirect=1):
  - FIFO cleared (count=0, pointers reset); out_valid=0 next cycle.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - drop = inflight_next, i.e. inflight after this cycle's response decrement. No request is issued this cycle.
  - A response arriving in the redirect cycle belongs to the old stream: it is discarded and is not counted in drop.
  - A pop requested in the redirect cycle is ignored.
  - Back-to-back redirects: each one reloads fetch_pc and recomputes drop; the last one wins.
  - Redirect while drop>0: drop = inflight_next, which already includes the older outstanding requests.
- New-stream requests may issue while drop>0. Credits still count all inflight requests.
- out_ready low: head held stable, and fetching continues until credits are exhausted.
- Counter widths: count, inflight, drop are $clog2(DEPTH+1) bits. fetch_pc wraps modulo 2^32.

Decomposition:
- Shared package (fetch_pkg):
  - XLEN=32, INSTR_BYTES=4
  - fetch_entry_t struct {instr[31:0], pc_4[31:0]}
  - ALIGN_MASK constant
- One sub-module: prefetch_fifo.
  - Parameterised DEPTH, synchronous FIFO of fetch_entry_t with push, pop, clear, count, head.
  - Async active-low reset on clk/rst.
- Top level keeps credit, drop and fetch_pc logic.

Test Plan:
- Reset, then memory with latency 1 and always ready, out_ready=1 → requests at 0x0,0x4,0x8…; first out_valid 2 cycles after run; out_pc_4 sequence 0x4,0x8,0xC.
- out_ready=0 for 10 cycles, latency 1 → exactly DEPTH=4 requests issued, count=4, imem_req_valid=0; release → 4 pops on consecutive cycles, then fetching resumes at 0x10.
- imem_req_ready toggling 1-0-1 with 3-cycle latency → addr held while not ready; no duplicated or skipped words; out_instr order matches addresses.
- Redirect to 0x103 with 2 requests in flight (latency 3) → fetch restarts at 0x100; 2 stale responses dropped; next out_instr is word@0x100 with out_pc_4=0x104.
- Redirect coinciding with rsp_valid and out_ready=1 → response discarded, no pop; out_valid=0 next cycle; drop equals remaining inflight.
- rst asserted mid-stream with 3 inflight and FIFO non-empty → all outputs at reset values immediately; after release, fetch restarts at RESET_PC and no stale entry appears.
